param_mode_fsm: RTL
===================

PARAM_MODE_FSM -- requirements
Module: param_mode_fsm

Interface
REQ-001 Parameter IN_W, default 3, user_input width (>=2).
REQ-002 Parameter OUT_W, default 3, out width (>=2).
REQ-003 Parameter HOLD_CYCLES, default 4, cycles spent in ACTIVE (>=1).
REQ-004 Parameter CNT_W, default 8, run_cnt width.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 in_valid  input  1  command present on user_input.
REQ-009 user_input  input  IN_W  command code.
REQ-010 in_ready  output  1  block accepts a command this cycle.
REQ-011 out  output  OUT_W  registered state-dependent output code.
REQ-012 state_o  output  3  registered current state encoding.
REQ-013 done  output  1  one-cycle pulse on normal ACTIVE completion.
REQ-014 err  output  1  sticky fault indicator.
REQ-015 run_cnt  output  CNT_W  count of completed ACTIVE runs.

Function
REQ-016 A command SHALL be accepted only on a rising edge with in_valid=1 and in_ready=1; its effect SHALL be visible on state_o/out after that edge.
REQ-017 in_ready SHALL be 1 in IDLE, ARMED and ACTIVE, and 0 in FAULT.
REQ-018 Command codes: NOP=0, ARM=1, GO=2, STOP=3; any value >=4 is illegal.
REQ-019 States: IDLE=3'd0, ARMED=3'd1, ACTIVE=3'd2, FAULT=3'd7; codes 3, 4, 5 and 6 are unencoded.
REQ-020 IDLE: ARM -> ARMED; NOP, GO or STOP -> stay.
REQ-021 ARMED: GO -> ACTIVE, hold counter loaded with HOLD_CYCLES-1; STOP -> IDLE; ARM or NOP -> stay.
REQ-022 ACTIVE: each cycle, if counter==0 -> IDLE, done=1 next cycle, run_cnt+1; else counter-1. ACTIVE lasts exactly HOLD_CYCLES cycles.
REQ-023 ACTIVE: accepted STOP -> IDLE immediately, no done pulse, run_cnt unchanged; ARM, GO or NOP ignored.
REQ-024 STOP on the expiry cycle (counter==0) SHALL take priority: IDLE, no done, run_cnt unchanged.
REQ-025 An accepted illegal command in any state SHALL -> FAULT and set err.
REQ-026 Any unencoded state value SHALL -> FAULT on the next edge and set err; no state may lock up.
REQ-027 FAULT SHALL be exited only by reset; err SHALL stay 1 until reset.
REQ-028 out SHALL be zero-extended state code: IDLE 0, ARMED 1, ACTIVE 2; FAULT all ones.
REQ-029 run_cnt SHALL wrap from 2^CNT_W-1 to 0.
REQ-030 done SHALL never be high for two consecutive cycles.

Reset
REQ-031 On rst=1, asynchronously: state=IDLE, out=0, state_o=0, done=0, err=0, run_cnt=0, hold counter=0.
REQ-032 Reset asserted mid-ACTIVE SHALL abort the run with no done pulse and no run_cnt increment.
REQ-033 in_ready SHALL be 1 in the first cycle after reset deassertion.

Structure
REQ-034 The state encodings, command codes and the FAULT/out constants SHALL live in shared package param_mode_fsm_pkg.
REQ-035 The hold counter SHALL be sub-module fsm_hold_cnt, with load, decrement and zero flag, parametrised by HOLD_CYCLES.
REQ-036 The next-state logic SHALL include a default branch mapping to FAULT.

Verification (HOLD_CYCLES=4, CNT_W=8)
REQ-037 Stimulus: ARM, GO, then idle.
Required response: state_o 1, then 2 for 4 cycles, then 0; done pulses once; run_cnt=1.
REQ-038 Stimulus: ARM, GO, STOP on the 4th ACTIVE cycle.
Required response: state_o 0; done stays 0; run_cnt stays 0.
REQ-039 Stimulus: user_input=5 with in_valid in ARMED.
Required response: state_o 7, out 3'b111, err 1, in_ready 0; remains until rst, then all outputs 0.
REQ-040 Stimulus: force state register to 4.
Required response: state_o 7 next edge; err=1.
REQ-041 Stimulus: 256 complete runs.
Required response: run_cnt wraps to 0; 256 done pulses, never adjacent.
REQ-042 Stimulus: rst pulsed on the 2nd ACTIVE cycle.
Required response: all outputs 0 immediately; no done pulse.

Source files
------------

// File: rtl/param_mode_fsm_pkg.sv
// param_mode_fsm_pkg
// Shared constants for the parameterised mode FSM: state encodings, command
// codes and the fill value used for the out code while in FAULT.
// No ports (package).
package param_mode_fsm_pkg;

  localparam int STATE_W = 3;

  // State encodings. Codes 3..6 are deliberately unused; the FSM treats any
  // of them as corruption and moves to FAULT.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARMED  = 3'd1;
  localparam logic [2:0] ST_ACTIVE = 3'd2;
  localparam logic [2:0] ST_FAULT  = 3'd7;

  // Command codes carried in the low two bits of user_input. Any set bit
  // above bit 1 makes the command illegal.
  localparam logic [1:0] CMD_NOP  = 2'd0;
  localparam logic [1:0] CMD_ARM  = 2'd1;
  localparam logic [1:0] CMD_GO   = 2'd2;
  localparam logic [1:0] CMD_STOP = 2'd3;

  // FAULT drives every bit of out to this value, whatever OUT_W is.
  localparam logic OUT_FAULT_BIT = 1'b1;

  // True for the three states that take commands.
  function automatic logic is_run_state(input logic [2:0] s);
    return (s == ST_IDLE) || (s == ST_ARMED) || (s == ST_ACTIVE);
  endfunction

endpackage

// File: rtl/param_mode_fsm_hold_cnt.sv
// fsm_hold_cnt
// Down-counter that times the ACTIVE phase. A load sets it to HOLD_CYCLES-1;
// each decrement lowers it by one, stopping at zero. zero is high whenever
// the count is zero.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (count -> 0)
//   load  load HOLD_CYCLES-1 (wins over dec)
//   dec   decrement by one
//   zero  count equals zero
module fsm_hold_cnt #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= LOAD_VAL;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CW'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/param_mode_fsm.sv
// param_mode_fsm
// Command-driven mode FSM: IDLE -> ARMED -> ACTIVE (timed by fsm_hold_cnt)
// -> IDLE, with a sticky FAULT state entered on illegal commands or
// corrupted state values and left only through reset.
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   in_valid    command present on user_input
//   user_input  command code (NOP/ARM/GO/STOP, >=4 illegal)
//   in_ready    commands are accepted this cycle (not in FAULT)
//   out         registered output code (state code, all ones in FAULT)
//   state_o     registered current state encoding
//   done        one-cycle pulse after a run completes normally
//   err         sticky fault flag
//   run_cnt     number of completed runs, wraps
module param_mode_fsm
  import param_mode_fsm_pkg::*;
#(
  parameter int IN_W        = 3,
  parameter int OUT_W       = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  user_input,
  output logic             in_ready,
  output logic [OUT_W-1:0] out,
  output logic [2:0]       state_o,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] run_cnt
);

  logic [2:0]       state_reg, state_next;
  logic [OUT_W-1:0] out_reg, out_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] run_cnt_reg, run_cnt_next;

  logic       accept;
  logic       cmd_illegal;
  logic [1:0] cmd;
  logic       cnt_load, cnt_dec, cnt_zero;

  // Only the upper bits decide legality; with IN_W == 2 every code is legal.
  generate
    if (IN_W > 2) begin : g_wide_cmd
      assign cmd_illegal = |user_input[IN_W-1:2];
    end else begin : g_narrow_cmd
      assign cmd_illegal = 1'b0;
    end
  endgenerate

  assign cmd      = user_input[1:0];
  assign in_ready = is_run_state(state_reg);
  assign accept   = in_valid && in_ready;

  fsm_hold_cnt #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    run_cnt_next = run_cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_illegal)         state_next = ST_FAULT;
          else if (cmd == CMD_ARM) state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (accept) begin
          if (cmd_illegal) begin
            state_next = ST_FAULT;
          end else if (cmd == CMD_GO) begin
            state_next = ST_ACTIVE;
            cnt_load   = 1'b1;
          end else if (cmd == CMD_STOP) begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_ACTIVE: begin
        // STOP beats expiry, so a stop on the last cycle still suppresses
        // done and the run count.
        if (accept && cmd_illegal) begin
          state_next = ST_FAULT;
        end else if (accept && (cmd == CMD_STOP)) begin
          state_next = ST_IDLE;
        end else if (cnt_zero) begin
          state_next   = ST_IDLE;
          done_next    = 1'b1;
          run_cnt_next = run_cnt_reg + CNT_W'(1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_FAULT;
      end
    endcase

    err_next = err_reg || (state_next == ST_FAULT);

    if (state_next == ST_FAULT) out_next = {OUT_W{OUT_FAULT_BIT}};
    else                        out_next = OUT_W'(state_next[1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      out_reg     <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      run_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      out_reg     <= out_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      run_cnt_reg <= run_cnt_next;
    end
  end

  assign out     = out_reg;
  assign state_o = state_reg;
  assign done    = done_reg;
  assign err     = err_reg;
  assign run_cnt = run_cnt_reg;

endmodule
